// File: rtl/axis_lane_unpacker.sv
// -----------------------------------------------------------------------------
// axis_lane_unpacker
//
// Splits each wide AXI-Stream word into LANES narrow beats, one lane per beat.
// The word is held in a data register together with a pending-lane mask and
// the word's tlast. The current lane is the lowest pending lane (MSB_FIRST=0)
// or the highest pending lane (MSB_FIRST=1). The input is ready again in the
// same cycle the last pending lane is handed off, so consecutive words stream
// with no bubble.
//
// Optional feature: define AXIS_LANE_UNPACKER_KEEP_EN to add the axis_i_tkeep
// port. Lanes whose keep bit is 0 are skipped; a word with no keep bits set is
// accepted and dropped. Without the macro every word emits all LANES beats.
//
// Ports
//   clk            clock, rising edge
//   sresetn        synchronous active-low reset
//   axis_i_tvalid  slave valid
//   axis_i_tready  slave ready (combinational from axis_o_tready when HOLD)
//   axis_i_tlast   slave packet end
//   axis_i_tdata   wide word, lane k = bits [(k+1)*AXIS_O_BYTES*8-1 -: AXIS_O_BYTES*8]
//   axis_i_tkeep   one bit per lane (only with AXIS_LANE_UNPACKER_KEEP_EN)
//   axis_o_tvalid  master valid
//   axis_o_tready  master ready
//   axis_o_tlast   master packet end, on the final beat of a tlast word
//   axis_o_tdata   narrow beat
//
// state  | meaning
// EMPTY  | no pending lanes, input ready
// HOLD   | word held, at least one lane left to emit
// -----------------------------------------------------------------------------
module axis_lane_unpacker #(
  parameter int AXIS_I_BYTES = 4,
  parameter int AXIS_O_BYTES = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                                  clk,
  input  logic                                  sresetn,
  input  logic                                  axis_i_tvalid,
  output logic                                  axis_i_tready,
  input  logic                                  axis_i_tlast,
  input  logic [AXIS_I_BYTES*8-1:0]             axis_i_tdata,
`ifdef AXIS_LANE_UNPACKER_KEEP_EN
  input  logic [AXIS_I_BYTES/AXIS_O_BYTES-1:0]  axis_i_tkeep,
`endif
  output logic                                  axis_o_tvalid,
  input  logic                                  axis_o_tready,
  output logic                                  axis_o_tlast,
  output logic [AXIS_O_BYTES*8-1:0]             axis_o_tdata
);

  localparam int LANES = AXIS_I_BYTES / AXIS_O_BYTES;
  localparam int LW    = AXIS_O_BYTES * 8;
  localparam int IDXW  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                    state_q;
  logic [AXIS_I_BYTES*8-1:0] data_q;
  logic [LANES-1:0]          mask_q;
  logic                      tlast_q;

  logic [LANES-1:0]          keep_in;
  logic [IDXW-1:0]           cur_idx;
  logic [LANES-1:0]          cur_onehot;
  logic [LANES-1:0]          rest_mask;
  logic                      is_last;
  logic                      o_hs;
  logic                      i_hs;

`ifdef AXIS_LANE_UNPACKER_KEEP_EN
  assign keep_in = axis_i_tkeep;
`else
  assign keep_in = '1;
`endif

  // Priority pick of the current lane. The loop direction makes the
  // last-written match the winner: lowest set bit for LSB-first, highest
  // for MSB-first.
  always_comb begin
    cur_idx = '0;
    if (MSB_FIRST == 0) begin
      for (int i = LANES - 1; i >= 0; i--)
        if (mask_q[i]) cur_idx = IDXW'(i);
    end else begin
      for (int i = 0; i < LANES; i++)
        if (mask_q[i]) cur_idx = IDXW'(i);
    end
  end

  always_comb begin
    cur_onehot = '0;
    cur_onehot[cur_idx] = 1'b1;
  end

  assign rest_mask     = mask_q & ~cur_onehot;
  assign is_last       = (rest_mask == '0);

  assign axis_o_tvalid = (state_q == S_HOLD);
  assign axis_o_tdata  = data_q[cur_idx*LW +: LW];
  assign axis_o_tlast  = axis_o_tvalid && tlast_q && is_last;

  assign o_hs          = axis_o_tvalid && axis_o_tready;
  // Ready while empty, or when the final pending lane leaves this cycle so
  // the next word lands with no gap.
  assign axis_i_tready = (state_q == S_EMPTY) || (o_hs && is_last);
  assign i_hs          = axis_i_tvalid && axis_i_tready;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      mask_q  <= '0;
      tlast_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (i_hs) begin
            data_q  <= axis_i_tdata;
            mask_q  <= keep_in;
            tlast_q <= axis_i_tlast;
            // An all-zero keep word is swallowed here without any beat.
            state_q <= (keep_in != '0) ? S_HOLD : S_EMPTY;
          end
        end
        S_HOLD: begin
          if (i_hs) begin
            data_q  <= axis_i_tdata;
            mask_q  <= keep_in;
            tlast_q <= axis_i_tlast;
            state_q <= (keep_in != '0) ? S_HOLD : S_EMPTY;
          end else if (o_hs) begin
            mask_q <= rest_mask;
            if (is_last) state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_lane_unpacker.sv
module tb_axis_lane_unpacker;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        i_tvalid;
  logic        i_tlast;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        o_tready;

  logic        i_tready0, o_tvalid0, o_tlast0;
  logic [7:0]  o_tdata0;
  logic        i_tready1, o_tvalid1, o_tlast1;
  logic [7:0]  o_tdata1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_lane_unpacker #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(0)) dut0 (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tready (i_tready0),
    .axis_i_tlast  (i_tlast),
    .axis_i_tdata  (i_tdata),
`ifdef AXIS_LANE_UNPACKER_KEEP_EN
    .axis_i_tkeep  (i_tkeep),
`endif
    .axis_o_tvalid (o_tvalid0),
    .axis_o_tready (o_tready),
    .axis_o_tlast  (o_tlast0),
    .axis_o_tdata  (o_tdata0)
  );

  // MSB-first instance shares all inputs; it emits the same number of beats
  // per word as dut0, so both stay in step.
  axis_lane_unpacker #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(1)) dut1 (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tready (i_tready1),
    .axis_i_tlast  (i_tlast),
    .axis_i_tdata  (i_tdata),
`ifdef AXIS_LANE_UNPACKER_KEEP_EN
    .axis_i_tkeep  (i_tkeep),
`endif
    .axis_o_tvalid (o_tvalid1),
    .axis_o_tready (o_tready),
    .axis_o_tlast  (o_tlast1),
    .axis_o_tdata  (o_tdata1)
  );

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic [3:0]  tk;
    logic        tl;
    logic        otr;
    logic        e_ov;
    logic        e_chkd;
    logic [7:0]  e_od;
    logic        e_ol;
    logic        e_itr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic tv, input logic [31:0] td, input logic [3:0] tk,
                     input logic tl, input logic otr, input logic e_ov,
                     input logic e_chkd, input logic [7:0] e_od,
                     input logic e_ol, input logic e_itr);
    vec_t v;
    v.tv = tv; v.td = td; v.tk = tk; v.tl = tl; v.otr = otr;
    v.e_ov = e_ov; v.e_chkd = e_chkd; v.e_od = e_od; v.e_ol = e_ol; v.e_itr = e_itr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, look at outputs 1 time unit later.
  task automatic cyc(input logic tv, input logic [31:0] td, input logic [3:0] tk,
                     input logic tl, input logic otr);
    @(negedge clk);
    i_tvalid = tv; i_tdata = td; i_tkeep = tk; i_tlast = tl; o_tready = otr;
    #1;
  endtask

  logic [7:0] exp_msb [4];

  initial begin
    sresetn  = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tkeep  = '0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sresetn = 1'b1;

    // reset state
    add(0, 32'h0,        4'h0, 0, 1,  0, 1, 8'h00, 0, 1);
    // single word, four lanes LSB first, tlast on last beat
    add(1, 32'h44332211, 4'hF, 1, 1,  0, 0, 8'h00, 0, 1);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h11, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h22, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h33, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h44, 1, 1);
    // back-to-back words, eight beats in eight cycles
    add(1, 32'h44332211, 4'hF, 0, 1,  0, 0, 8'h00, 0, 1);
    add(1, 32'h88776655, 4'hF, 1, 1,  1, 1, 8'h11, 0, 0);
    add(1, 32'h88776655, 4'hF, 1, 1,  1, 1, 8'h22, 0, 0);
    add(1, 32'h88776655, 4'hF, 1, 1,  1, 1, 8'h33, 0, 0);
    add(1, 32'h88776655, 4'hF, 1, 1,  1, 1, 8'h44, 0, 1);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h55, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h66, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h77, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'h88, 1, 1);
    // output stalls: data and tlast hold while ready is low
    add(1, 32'hA4A3A2A1, 4'hF, 1, 1,  0, 0, 8'h00, 0, 1);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'hA1, 0, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA2, 0, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA2, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'hA2, 0, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA3, 0, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA3, 0, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'hA3, 0, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA4, 1, 0);
    add(0, 32'h0,        4'h0, 0, 0,  1, 1, 8'hA4, 1, 0);
    add(0, 32'h0,        4'h0, 0, 1,  1, 1, 8'hA4, 1, 1);
    add(0, 32'h0,        4'h0, 0, 1,  0, 0, 8'h00, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].tv, tbl[i].td, tbl[i].tk, tbl[i].tl, tbl[i].otr);
      chk($sformatf("vec%0d_ovalid", i), 32'(o_tvalid0), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_itready", i), 32'(i_tready0), 32'(tbl[i].e_itr));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_odata", i), 32'(o_tdata0), 32'(tbl[i].e_od));
        chk($sformatf("vec%0d_olast", i), 32'(o_tlast0), 32'(tbl[i].e_ol));
      end else begin
        chk($sformatf("vec%0d_olast_idle", i), 32'(o_tlast0), 32'd0);
        if (tbl[i].e_chkd)
          chk($sformatf("vec%0d_odata_rst", i), 32'(o_tdata0), 32'(tbl[i].e_od));
      end
    end

    // MSB-first order
    exp_msb[0] = 8'h44; exp_msb[1] = 8'h33; exp_msb[2] = 8'h22; exp_msb[3] = 8'h11;
    cyc(1, 32'h44332211, 4'hF, 1, 1);
    chk("msb_capture_ovalid", 32'(o_tvalid1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 32'h0, 4'h0, 0, 1);
      chk($sformatf("msb_beat%0d_ovalid", k), 32'(o_tvalid1), 32'd1);
      chk($sformatf("msb_beat%0d_odata", k), 32'(o_tdata1), 32'(exp_msb[k]));
      chk($sformatf("msb_beat%0d_olast", k), 32'(o_tlast1), (k == 3) ? 32'd1 : 32'd0);
    end
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("msb_after_ovalid", 32'(o_tvalid1), 32'd0);

`ifdef AXIS_LANE_UNPACKER_KEEP_EN
    // sparse keep: lanes 0 and 2 only
    cyc(1, 32'hDDCCBBAA, 4'b0101, 1, 1);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("keep_b0_lsb_data", 32'(o_tdata0), 32'hAA);
    chk("keep_b0_lsb_last", 32'(o_tlast0), 32'd0);
    chk("keep_b0_msb_data", 32'(o_tdata1), 32'hCC);
    chk("keep_b0_msb_last", 32'(o_tlast1), 32'd0);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("keep_b1_lsb_data", 32'(o_tdata0), 32'hCC);
    chk("keep_b1_lsb_last", 32'(o_tlast0), 32'd1);
    chk("keep_b1_lsb_itready", 32'(i_tready0), 32'd1);
    chk("keep_b1_msb_data", 32'(o_tdata1), 32'hAA);
    chk("keep_b1_msb_last", 32'(o_tlast1), 32'd1);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("keep_done_ovalid", 32'(o_tvalid0), 32'd0);
    // all-zero keep: swallowed, no beat
    cyc(1, 32'h12345678, 4'h0, 1, 1);
    chk("keep0_itready", 32'(i_tready0), 32'd1);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("keep0_ovalid", 32'(o_tvalid0), 32'd0);
    chk("keep0_itready_after", 32'(i_tready0), 32'd1);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("keep0_ovalid_2", 32'(o_tvalid0), 32'd0);
`endif

    // reset in the middle of a word
    cyc(1, 32'h12345678, 4'hF, 1, 1);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("rst_beat0_data", 32'(o_tdata0), 32'h78);
    cyc(0, 32'h0, 4'h0, 0, 1);
    chk("rst_beat1_data", 32'(o_tdata0), 32'h56);
    @(negedge clk);
    sresetn = 1'b0;
    @(negedge clk);
    sresetn = 1'b1;
    #1;
    chk("rst_ovalid", 32'(o_tvalid0), 32'd0);
    chk("rst_itready", 32'(i_tready0), 32'd1);
    chk("rst_odata", 32'(o_tdata0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 32'h0, 4'h0, 0, 1);
      chk($sformatf("rst_no_residual%0d", k), 32'(o_tvalid0), 32'd0);
      chk($sformatf("rst_no_residual_msb%0d", k), 32'(o_tvalid1), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
